approx_prod_accum: RTL

- Downstream consumer of the 8x8 inexact multiplier's 16-bit product `prod8`.
- Accumulates a fixed-length burst of LEN products into one saturating sum, e.g. an approximate dot product or FIR tap sum.
- valid/ready handshake on both input and output.
- Registers the result and holds it until the downstream stage takes it.

---
 rtl/approx_prod_accum.sv | 101 ++++++++++
 1 files changed

// File: rtl/approx_prod_accum.sv
// rtl/approx_prod_accum.sv - saturating burst accumulator for approximate 16-bit products
// Sums LEN accepted products into an ACC_W-bit sticky-saturating result held until taken.
module approx_prod_accum #(
  parameter int LEN   = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             sat_flag, sat_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ACC_W-1:0] out_sum_nxt;
  logic             out_sat_nxt;

  // One guard bit catches overflow of the unsigned add.
  logic [ACC_W:0]   sum_ext;
  logic             sat_beat;
  logic [ACC_W-1:0] acc_beat;

  assign sum_ext  = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, in_prod};
  assign sat_beat = sat_flag | sum_ext[ACC_W];
  assign acc_beat = sat_beat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACC;
      acc      <= '0;
      sat_flag <= 1'b0;
      beat_cnt <= '0;
      out_sum  <= '0;
      out_sat  <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      sat_flag <= sat_nxt;
      beat_cnt <= cnt_nxt;
      out_sum  <= out_sum_nxt;
      out_sat  <= out_sat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    sat_nxt     = sat_flag;
    cnt_nxt     = beat_cnt;
    out_sum_nxt = out_sum;
    out_sat_nxt = out_sat;
    // Abort wins over everything, including a beat offered in the same cycle.
    if (clr) begin
      state_nxt = ST_ACC;
      acc_nxt   = '0;
      sat_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            if (beat_cnt == LAST) begin
              out_sum_nxt = acc_beat;
              out_sat_nxt = sat_beat;
              state_nxt   = ST_DONE;
              acc_nxt     = '0;
              sat_nxt     = 1'b0;
              cnt_nxt     = '0;
            end else begin
              acc_nxt = acc_beat;
              sat_nxt = sat_beat;
              cnt_nxt = beat_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_nxt = ST_ACC;
        end
        default: state_nxt = ST_ACC;
      endcase
    end
  end

endmodule
